mdu_seq: RTL and testbench

Multi-cycle multiply/divide sequencer for the pipelined CPU. It sits beside the EX stage and accepts MULT/MULTU/DIV/DIVU issues from the decoder. It runs a 32-iteration shift-add multiply or restoring divide on an internal datapath and owns the architectural HI/LO registers. While busy it stalls any instruction in EX that touches HI/LO, so the hazard logic never needs to know the unit's latency.

---
 rtl/mdu_seq.sv | 203 ++++++++++++++++++++
 tb/tb_mdu_seq.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mdu_seq.sv
// Multi-cycle multiply/divide sequencer owning the architectural HI/LO registers.
// Shift-add multiply or restoring divide, one bit per cycle, with a final sign-fixup cycle.
module mdu_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             mt_hi,
  input  logic             mt_lo,
  input  logic [WIDTH-1:0] mt_data,
  input  logic             rd_req,
  output logic             busy,
  output logic             stall,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             done
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    FIX  = 2'b10
  } state_e;

  state_e             state_r;
  logic [CW-1:0]      cnt_r;
  logic [2*WIDTH-1:0] acc_r;
  logic [WIDTH-1:0]   bmag_r;
  logic [WIDTH-1:0]   a_r;
  logic [1:0]         op_r;
  logic               neg_q_r;
  logic               neg_r_r;
  logic               bzero_r;
  logic               busy_r;
  logic               done_r;
  logic [WIDTH-1:0]   hi_r;
  logic [WIDTH-1:0]   lo_r;

  logic               sa_s;
  logic               sb_s;
  logic [WIDTH-1:0]   amag_s;
  logic [WIDTH-1:0]   bmag_s;
  logic [WIDTH:0]     mul_sum_s;
  logic [2*WIDTH-1:0] mul_next_s;
  logic [WIDTH:0]     rem_sh_s;
  logic [WIDTH:0]     diff_s;
  logic               qbit_s;
  logic [2*WIDTH-1:0] div_next_s;
  logic [2*WIDTH-1:0] prod_s;
  logic [WIDTH-1:0]   fix_hi_s;
  logic [WIDTH-1:0]   fix_lo_s;

  // Operand sign extraction and magnitude conversion at issue
  always_comb begin
    sa_s   = op[0] & a[WIDTH-1];
    sb_s   = op[0] & b[WIDTH-1];
    amag_s = a;
    bmag_s = b;
    if (sa_s) begin
      amag_s = -a;
    end else begin
      amag_s = a;
    end
    if (sb_s) begin
      bmag_s = -b;
    end else begin
      bmag_s = b;
    end
  end

  // One iteration of shift-add multiply and of restoring divide
  always_comb begin
    mul_sum_s  = {1'b0, acc_r[2*WIDTH-1:WIDTH]};
    if (acc_r[0]) begin
      mul_sum_s = {1'b0, acc_r[2*WIDTH-1:WIDTH]} + {1'b0, bmag_r};
    end else begin
      mul_sum_s = {1'b0, acc_r[2*WIDTH-1:WIDTH]};
    end
    mul_next_s = {mul_sum_s, acc_r[WIDTH-1:1]};

    // Remainder lives in the upper word, dividend/quotient in the lower word
    rem_sh_s   = {acc_r[2*WIDTH-1:WIDTH], acc_r[WIDTH-1]};
    diff_s     = rem_sh_s - {1'b0, bmag_r};
    qbit_s     = ~diff_s[WIDTH];
    if (qbit_s) begin
      div_next_s = {diff_s[WIDTH-1:0], acc_r[WIDTH-2:0], 1'b1};
    end else begin
      div_next_s = {rem_sh_s[WIDTH-1:0], acc_r[WIDTH-2:0], 1'b0};
    end
  end

  // Final HI/LO values including sign fixup and the divide-by-zero result
  always_comb begin
    prod_s   = acc_r;
    fix_hi_s = acc_r[2*WIDTH-1:WIDTH];
    fix_lo_s = acc_r[WIDTH-1:0];
    if (!op_r[1]) begin
      if (neg_q_r) begin
        prod_s = -acc_r;
      end else begin
        prod_s = acc_r;
      end
      fix_hi_s = prod_s[2*WIDTH-1:WIDTH];
      fix_lo_s = prod_s[WIDTH-1:0];
    end else if (bzero_r) begin
      fix_hi_s = a_r;
      fix_lo_s = {WIDTH{1'b1}};
    end else begin
      if (neg_q_r) begin
        fix_lo_s = -acc_r[WIDTH-1:0];
      end else begin
        fix_lo_s = acc_r[WIDTH-1:0];
      end
      if (neg_r_r) begin
        fix_hi_s = -acc_r[2*WIDTH-1:WIDTH];
      end else begin
        fix_hi_s = acc_r[2*WIDTH-1:WIDTH];
      end
    end
  end

  // Sequencer FSM, datapath registers and architectural HI/LO
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      cnt_r   <= {CW{1'b0}};
      acc_r   <= {(2*WIDTH){1'b0}};
      bmag_r  <= {WIDTH{1'b0}};
      a_r     <= {WIDTH{1'b0}};
      op_r    <= 2'b00;
      neg_q_r <= 1'b0;
      neg_r_r <= 1'b0;
      bzero_r <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      hi_r    <= {WIDTH{1'b0}};
      lo_r    <= {WIDTH{1'b0}};
    end else begin
      done_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (start) begin
            acc_r   <= {{WIDTH{1'b0}}, amag_s};
            bmag_r  <= bmag_s;
            a_r     <= a;
            op_r    <= op;
            neg_q_r <= sa_s ^ sb_s;
            neg_r_r <= sa_s;
            bzero_r <= (b == {WIDTH{1'b0}});
            cnt_r   <= {CW{1'b0}};
            busy_r  <= 1'b1;
            state_r <= RUN;
          end else begin
            if (mt_hi) begin
              hi_r <= mt_data;
            end
            if (mt_lo) begin
              lo_r <= mt_data;
            end
          end
        end
        RUN: begin
          if (op_r[1]) begin
            acc_r <= div_next_s;
          end else begin
            acc_r <= mul_next_s;
          end
          if (cnt_r == CW'(WIDTH - 1)) begin
            state_r <= FIX;
          end else begin
            cnt_r <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
          end
        end
        FIX: begin
          hi_r    <= fix_hi_s;
          lo_r    <= fix_lo_s;
          busy_r  <= 1'b0;
          done_r  <= 1'b1;
          cnt_r   <= {CW{1'b0}};
          state_r <= IDLE;
        end
        default: begin
          busy_r  <= 1'b0;
          cnt_r   <= {CW{1'b0}};
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign busy  = busy_r;
  assign done  = done_r;
  assign hi    = hi_r;
  assign lo    = lo_r;
  assign stall = busy_r & (start | mt_hi | mt_lo | rd_req);

endmodule

// File: tb/tb_mdu_seq.sv
// Directed self-checking bench for mdu_seq: timing, signed/unsigned results,
// divide corner cases, stall behaviour, MTHI/MTLO and mid-operation reset.
module tb_mdu_seq;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        mt_hi;
  logic        mt_lo;
  logic [31:0] mt_data;
  logic        rd_req;
  logic        busy;
  logic        stall;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        done;

  int checks;
  int errors;

  mdu_seq #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
    .mt_hi(mt_hi), .mt_lo(mt_lo), .mt_data(mt_data), .rd_req(rd_req),
    .busy(busy), .stall(stall), .hi(hi), .lo(lo), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Waits (bounded) for done; cyc counts cycles after the start cycle
  task automatic wait_done(output int cyc, output int bcnt);
    cyc  = 1;
    bcnt = 0;
    while (done !== 1'b1 && cyc < 60) begin
      if (busy === 1'b1) bcnt++;
      tick();
      cyc++;
    end
  endtask

  task automatic issue(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    start = 1'b1; op = o; a = x; b = y;
    tick();
  endtask

  task automatic test_reset();
    #3;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || hi !== 32'h0 || lo !== 32'h0 || stall !== 1'b0) begin
      errors++;
      $display("FAIL reset: busy=%b done=%b hi=%h lo=%h stall=%b, want all 0", busy, done, hi, lo, stall);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_multu();
    int cyc, bcnt;
    issue(2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF);
    start = 1'b0;
    wait_done(cyc, bcnt);
    checks++;
    if (cyc !== 34) begin
      errors++;
      $display("FAIL multu_latency: done at cycle %0d, want 34", cyc);
    end
    checks++;
    if (bcnt !== 33) begin
      errors++;
      $display("FAIL multu_busy_cycles: got %0d, want 33", bcnt);
    end
    checks++;
    if (hi !== 32'hFFFFFFFE || lo !== 32'h00000001 || busy !== 1'b0) begin
      errors++;
      $display("FAIL multu_result: hi=%h lo=%h busy=%b, want FFFFFFFE 00000001 0", hi, lo, busy);
    end
    tick();
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL multu_done_pulse: done=%b, want 0", done);
    end
  endtask

  task automatic test_back_to_back();
    int cyc, bcnt;
    issue(2'b01, 32'hFFFFFFFD, 32'd5);
    op = 2'b11; a = 32'hFFFFFFF9; b = 32'd2;
    #1;
    checks++;
    if (stall !== 1'b1) begin
      errors++;
      $display("FAIL b2b_stall_held: stall=%b, want 1", stall);
    end
    wait_done(cyc, bcnt);
    checks++;
    if (cyc !== 34 || hi !== 32'hFFFFFFFF || lo !== 32'hFFFFFFF1 || stall !== 1'b0) begin
      errors++;
      $display("FAIL mult_result: cyc=%0d hi=%h lo=%h stall=%b, want 34 FFFFFFFF FFFFFFF1 0", cyc, hi, lo, stall);
    end
    tick();
    start = 1'b0;
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL b2b_accept: busy=%b, want 1", busy);
    end
    wait_done(cyc, bcnt);
    checks++;
    if (cyc !== 34 || lo !== 32'hFFFFFFFD || hi !== 32'hFFFFFFFF) begin
      errors++;
      $display("FAIL div_result: cyc=%0d hi=%h lo=%h, want 34 FFFFFFFF FFFFFFFD", cyc, hi, lo);
    end
    tick();
  endtask

  task automatic test_div_corners();
    int cyc, bcnt;
    issue(2'b10, 32'd7, 32'd0);
    start = 1'b0;
    wait_done(cyc, bcnt);
    checks++;
    if (lo !== 32'hFFFFFFFF || hi !== 32'd7) begin
      errors++;
      $display("FAIL divu_by_zero: hi=%h lo=%h, want 00000007 FFFFFFFF", hi, lo);
    end
    tick();
    issue(2'b11, 32'hFFFFFFF9, 32'd0);
    start = 1'b0;
    wait_done(cyc, bcnt);
    checks++;
    if (lo !== 32'hFFFFFFFF || hi !== 32'hFFFFFFF9) begin
      errors++;
      $display("FAIL div_by_zero_signed: hi=%h lo=%h, want FFFFFFF9 FFFFFFFF", hi, lo);
    end
    tick();
    issue(2'b11, 32'h80000000, 32'hFFFFFFFF);
    start = 1'b0;
    wait_done(cyc, bcnt);
    checks++;
    if (lo !== 32'h80000000 || hi !== 32'h0) begin
      errors++;
      $display("FAIL div_overflow: hi=%h lo=%h, want 00000000 80000000", hi, lo);
    end
    tick();
  endtask

  task automatic test_stall_mt();
    int cyc, bcnt, bad;
    issue(2'b10, 32'd100, 32'd7);
    start = 1'b0; rd_req = 1'b1;
    bad = 0;
    cyc = 1;
    while (done !== 1'b1 && cyc < 60) begin
      #1;
      if (stall !== 1'b1) bad++;
      tick();
      cyc++;
    end
    checks++;
    if (bad !== 0 || cyc !== 34) begin
      errors++;
      $display("FAIL rd_stall_busy: %0d non-stall cycles, done at %0d, want 0 and 34", bad, cyc);
    end
    checks++;
    if (stall !== 1'b0 || lo !== 32'd14 || hi !== 32'd2) begin
      errors++;
      $display("FAIL rd_done_cycle: stall=%b lo=%0d hi=%0d, want 0 14 2", stall, lo, hi);
    end
    tick();
    rd_req = 1'b0;
    issue(2'b00, 32'd3, 32'd4);
    start = 1'b0; mt_lo = 1'b1; mt_data = 32'h1234;
    #1;
    checks++;
    if (stall !== 1'b1) begin
      errors++;
      $display("FAIL mtlo_stall: stall=%b, want 1", stall);
    end
    wait_done(cyc, bcnt);
    checks++;
    if (lo !== 32'd12 || stall !== 1'b0) begin
      errors++;
      $display("FAIL mtlo_held_off: lo=%h stall=%b, want 0000000c 0", lo, stall);
    end
    tick();
    mt_lo = 1'b0;
    checks++;
    if (lo !== 32'h1234 || hi !== 32'h0) begin
      errors++;
      $display("FAIL mtlo_lands: lo=%h hi=%h, want 00001234 00000000", lo, hi);
    end
  endtask

  task automatic test_mt_idle();
    int cyc, bcnt;
    mt_hi = 1'b1; mt_data = 32'hDEAD;
    issue(2'b00, 32'd2, 32'd3);
    start = 1'b0; mt_hi = 1'b0;
    checks++;
    if (busy !== 1'b1 || hi !== 32'h0) begin
      errors++;
      $display("FAIL start_beats_mthi: busy=%b hi=%h, want 1 00000000", busy, hi);
    end
    wait_done(cyc, bcnt);
    checks++;
    if (hi !== 32'h0 || lo !== 32'd6) begin
      errors++;
      $display("FAIL start_mthi_result: hi=%h lo=%h, want 00000000 00000006", hi, lo);
    end
    tick();
    mt_hi = 1'b1; mt_data = 32'hABCD; rd_req = 1'b1;
    #1;
    checks++;
    if (stall !== 1'b0) begin
      errors++;
      $display("FAIL idle_stall: stall=%b, want 0", stall);
    end
    tick();
    mt_hi = 1'b0; rd_req = 1'b0;
    checks++;
    if (hi !== 32'hABCD || lo !== 32'd6) begin
      errors++;
      $display("FAIL mthi_idle: hi=%h lo=%h, want 0000abcd 00000006", hi, lo);
    end
  endtask

  task automatic test_async_reset();
    int cyc, bcnt, dcnt;
    issue(2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF);
    start = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || hi !== 32'h0 || lo !== 32'h0 || done !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: busy=%b hi=%h lo=%h done=%b, want 0", busy, hi, lo, done);
    end
    tick();
    tick();
    rst_n = 1'b1;
    dcnt = 0;
    for (int i = 0; i < 40; i++) begin
      if (done === 1'b1) dcnt++;
      tick();
    end
    checks++;
    if (dcnt !== 0) begin
      errors++;
      $display("FAIL reset_no_done: %0d done pulses, want 0", dcnt);
    end
    issue(2'b00, 32'd6, 32'd7);
    start = 1'b0;
    wait_done(cyc, bcnt);
    checks++;
    if (lo !== 32'd42 || hi !== 32'h0 || cyc !== 34) begin
      errors++;
      $display("FAIL post_reset_multu: lo=%0d hi=%h cyc=%0d, want 42 00000000 34", lo, hi, cyc);
    end
    tick();
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    rst_n   = 1'b0;
    start   = 1'b0;
    op      = 2'b00;
    a       = 32'h0;
    b       = 32'h0;
    mt_hi   = 1'b0;
    mt_lo   = 1'b0;
    mt_data = 32'h0;
    rd_req  = 1'b0;
    test_reset();
    test_multu();
    test_back_to_back();
    test_div_corners();
    test_stall_mt();
    test_mt_idle();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
